// File: rtl/vga_timing_gen.sv
// Raster timing source and pixel output stage: free-running hcnt/vcnt for the address
// decoder, plus sync/blank/RGB delayed to line up with the returned video_data.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned DATA_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] video_data,
  output logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       sync_b,
  output logic       blank_b,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DivLast = 4'(CLK_DIV - 1);
  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct    = 10'(H_ACTIVE);
  localparam logic [9:0] VAct    = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic vs;
    logic hs;
  } tim_t;

  localparam tim_t TimIdle = '{act: 1'b0, vs: 1'b1, hs: 1'b1};

  // ---------------------------------------------------------------------------
  // Pixel clock divider
  // ---------------------------------------------------------------------------
  logic [3:0] div_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 4'd1;
    end
  end

  // Gated by reset so no tick can ever be seen while reset is held.
  assign pix_en = ~reset & (div_q == DivLast);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [9:0] hcnt_q, vcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (pix_en) begin
      if (hcnt_q == HLast) begin
        hcnt_q <= '0;
        vcnt_q <= (vcnt_q == VLast) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_q <= hcnt_q + 10'd1;
      end
    end
  end

  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;

  // ---------------------------------------------------------------------------
  // Raw timing from the undelayed counters
  // ---------------------------------------------------------------------------
  tim_t raw;

  always_comb begin
    raw     = TimIdle;
    raw.hs  = ~((hcnt_q >= HsStart) && (hcnt_q < HsEnd));
    raw.vs  = ~((vcnt_q >= VsStart) && (vcnt_q < VsEnd));
    raw.act = (hcnt_q < HAct) && (vcnt_q < VAct);
  end

  // ---------------------------------------------------------------------------
  // Alignment shift register: matches the memory read latency in pixel ticks
  // ---------------------------------------------------------------------------
  tim_t aligned;

  if (DATA_LAT == 0) begin : g_no_lat
    assign aligned = raw;
  end else begin : g_lat
    tim_t pipe_q [DATA_LAT];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DATA_LAT; i++) begin
          pipe_q[i] <= TimIdle;
        end
      end else if (pix_en) begin
        pipe_q[0] <= raw;
        for (int unsigned i = 1; i < DATA_LAT; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign aligned = pipe_q[DATA_LAT-1];
  end

  // ---------------------------------------------------------------------------
  // RGB332 expansion, forced black outside the visible area
  // ---------------------------------------------------------------------------
  logic [7:0] r_d, g_d, b_d;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (aligned.act) begin
      r_d = {video_data[7:5], video_data[7:5], video_data[7:6]};
      g_d = {video_data[4:2], video_data[4:2], video_data[4:3]};
      b_d = {video_data[1:0], video_data[1:0], video_data[1:0], video_data[1:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic       hsync_q, vsync_q, blank_q, fs_q;
  logic [7:0] r_q, g_q, b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= pix_en && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
      if (pix_en) begin
        hsync_q <= aligned.hs;
        vsync_q <= aligned.vs;
        blank_q <= aligned.act;
        r_q     <= r_d;
        g_q     <= g_d;
        b_q     <= b_d;
      end
    end
  end

  assign frame_start = fs_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign sync_b      = hsync_q & vsync_q;
  assign blank_b     = blank_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster, with a second CLK_DIV=1 instance.
module tb_vga_timing_gen;

  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int unsigned CD = 2, DL = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] video_data = 8'h00;

  logic       pix_en, frame_start, hsync, vsync, sync_b, blank_b;
  logic [9:0] hcnt, vcnt;
  logic [7:0] R, G, B;

  logic       pix_en1, frame_start1, hsync1, vsync1, sync_b1, blank_b1;
  logic [9:0] hcnt1, vcnt1;
  logic [7:0] r1, g1, b1;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .DATA_LAT(DL)
  ) dut (
    .clk(clk), .reset(reset), .video_data(video_data), .pix_en(pix_en),
    .hcnt(hcnt), .vcnt(vcnt), .frame_start(frame_start), .hsync(hsync),
    .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b), .R(R), .G(G), .B(B)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(1), .DATA_LAT(DL)
  ) dut_div1 (
    .clk(clk), .reset(reset), .video_data(video_data), .pix_en(pix_en1),
    .hcnt(hcnt1), .vcnt(vcnt1), .frame_start(frame_start1), .hsync(hsync1),
    .vsync(vsync1), .sync_b(sync_b1), .blank_b(blank_b1), .R(r1), .G(g1), .B(b1)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic px_t inact();
    px_t p;
    p = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    return p;
  endfunction

  // Memory contents: a fixed colour on line 0, the column number on odd lines.
  function automatic logic [7:0] mem_f(input int unsigned h, input int unsigned v);
    int unsigned t;
    t = h * 5 + v * 3;
    if (v == 0) return 8'hE3;
    if (v % 2 == 1) return 8'(h);
    return 8'(t);
  endfunction

  function automatic px_t expect_px(input int unsigned h, input int unsigned v);
    px_t        p;
    logic [7:0] d;
    d     = mem_f(h, v);
    p     = '0;
    p.hs  = !(h >= HA + HF && h < HA + HF + HS);
    p.vs  = !(v >= VA + VF && v < VA + VF + VS);
    p.act = (h < HA) && (v < VA);
    if (p.act) begin
      p.r = {d[7:5], d[7:5], d[7:6]};
      p.g = {d[4:2], d[4:2], d[4:3]};
      p.b = {4{d[1:0]}};
    end
    return p;
  endfunction

  // Reference state: what the DUT should hold after the most recent posedge.
  px_t         exp_q[$];
  px_t         m_out;
  int unsigned m_div, mh, mv, h1, v1;
  int unsigned p1h, p1v, p2h, p2v;
  logic        m_fs;
  int          hs_fall, vs_fall, fs_last;
  logic        hs_prev, vs_prev;

  task automatic cycle(input logic rst_v);
    logic pix;
    @(negedge clk);
    cyc++;
    pix = !reset && (m_div == CD - 1);
    check("pix_en", pix_en, pix);
    check("hcnt", hcnt, mh);
    check("vcnt", vcnt, mv);
    check("frame_start", frame_start, m_fs);
    check("hsync", hsync, m_out.hs);
    check("vsync", vsync, m_out.vs);
    check("sync_b", sync_b, m_out.hs & m_out.vs);
    check("blank_b", blank_b, m_out.act);
    check("R", R, m_out.r);
    check("G", G, m_out.g);
    check("B", B, m_out.b);
    check("div1_pix_en", pix_en1, !reset);
    check("div1_hcnt", hcnt1, h1);
    check("div1_vcnt", vcnt1, v1);

    if (reset) begin
      hs_fall = -1;
      vs_fall = -1;
      fs_last = -1;
    end else begin
      if (hs_prev && !hsync) hs_fall = cyc;
      if (!hs_prev && hsync && hs_fall >= 0) check("hsync_width", cyc - hs_fall, HS * CD);
      if (vs_prev && !vsync) vs_fall = cyc;
      if (!vs_prev && vsync && vs_fall >= 0) check("vsync_width", cyc - vs_fall, VS * HT * CD);
      if (frame_start) begin
        if (fs_last >= 0) check("frame_period", cyc - fs_last, HT * VT * CD);
        fs_last = cyc;
      end
    end
    hs_prev = hsync;
    vs_prev = vsync;

    // Drive inputs for the next posedge; off-tick data is junk the DUT must ignore.
    reset      = rst_v;
    pix        = !rst_v && (m_div == CD - 1);
    video_data = pix ? mem_f(p2h, p2v) : 8'($urandom);

    if (rst_v) begin
      m_div = 0;
      mh    = 0;
      mv    = 0;
      h1    = 0;
      v1    = 0;
      m_fs  = 1'b0;
      m_out = inact();
      exp_q.delete();
      repeat (DL) exp_q.push_back(inact());
    end else begin
      m_fs = pix && (mh == 0) && (mv == 0);
      if (pix) begin
        exp_q.push_back(expect_px(mh, mv));
        m_out = exp_q.pop_front();
        p2h = p1h; p2v = p1v;
        p1h = mh;  p1v = mv;
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      m_div = (m_div == CD - 1) ? 0 : m_div + 1;
      if (h1 == HT - 1) begin
        h1 = 0;
        v1 = (v1 == VT - 1) ? 0 : v1 + 1;
      end else begin
        h1++;
      end
    end
  endtask

  initial begin
    int k;
    m_div = 0; mh = 0; mv = 0; h1 = 0; v1 = 0;
    p1h = 0; p1v = 0; p2h = 0; p2v = 0;
    m_fs = 1'b0;
    m_out = inact();
    repeat (DL) exp_q.push_back(inact());
    hs_fall = -1; vs_fall = -1; fs_last = -1;
    hs_prev = 1'b1; vs_prev = 1'b1;

    repeat (4) cycle(1'b1);
    repeat (2 * HT * VT * CD + 40) cycle(1'b0);

    // Mid-line reset for a single clock
    k = 0;
    while (!(mh == 10 && mv == 3) && k < 4 * HT * VT * CD) begin
      cycle(1'b0);
      k++;
    end
    check("reach_mid_line", (mh == 10 && mv == 3), 1);
    cycle(1'b1);
    repeat (HT * VT * CD + HT * CD) cycle(1'b0);
    cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source and pixel output stage of the VGA path.
- Generates the free-running hcnt/vcnt counters consumed by the address decoder.
- Accepts the returned 8-bit video_data and drives R/G/B, hsync, vsync, sync_b and blank_b delayed so they align with that data.
- Sits between the system clock domain and the DAC/monitor pins; it is the producing end of the counter → address → data loop.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (1..16)
- DATA_LAT, 2, pixel ticks from hcnt/vcnt change to valid video_data (0..7)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- video_data  in  8  pixel from video memory, RGB332 format
- pix_en  out  1  one-clk pixel tick strobe
- hcnt  out  10  horizontal counter, undelayed, 0..H_TOTAL-1
- vcnt  out  10  vertical counter, undelayed, 0..V_TOTAL-1
- frame_start  out  1  one-clk pulse at the pixel tick where hcnt=0 and vcnt=0
- hsync  out  1  active-low horizontal sync, aligned to R/G/B
- vsync  out  1  active-low vertical sync, aligned to R/G/B
- sync_b  out  1  composite sync, equal to hsync & vsync, aligned
- blank_b  out  1  high in the visible area, aligned
- R, G, B  out  8 each  pixel colour, registered and aligned

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL likewise (default 525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div_cnt == CLK_DIV-1), so it is high one clk in every CLK_DIV.
  - With CLK_DIV=1, pix_en is constantly 1 outside reset.
- Counters:
  - Counters advance only on cycles with pix_en.
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps from V_TOTAL-1 to 0 on the same tick that hcnt wraps.
  - Both counters are registered.
- Raw timing, combinational from the current counters:
  - hs_raw = 0 when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (default 656..751), otherwise 1.
  - vs_raw = 0 when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (default 490..491), otherwise 1.
  - act_raw = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Alignment pipeline:
  - hs_raw, vs_raw and act_raw pass through a DATA_LAT-stage shift register that advances only on pix_en, followed by one output register.
  - The output register also samples video_data, on pix_en only.
  - Result: the outputs for pixel (h,v) appear DATA_LAT+1 pixel ticks after hcnt/vcnt = (h,v).
  - Outputs hold their values between pix_en ticks.
- Colour expansion (at the output register, RGB332):
  - R = {d[7:5], d[7:5], d[7:6]}
  - G = {d[4:2], d[4:2], d[4:3]}
  - B = {d[1:0], d[1:0], d[1:0], d[1:0]}
  - When the aligned act bit is 0, R/G/B = 0 regardless of video_data.
- frame_start:
  - Registered; asserted for exactly one clk, in the cycle after the pix_en on which hcnt=0 and vcnt=0.
- Reset (synchronous; takes priority over every other event, including a pix_en in the same cycle):
  - div_cnt, hcnt and vcnt go to 0.
  - All pipeline stages load inactive values: hs=1, vs=1, act=0.
  - Outputs: hsync=1, vsync=1, sync_b=1, blank_b=0, R=G=B=0, frame_start=0.
  - pix_en=0 while reset is high.
- After reset release:
  - First pix_en occurs CLK_DIV-1 cycles later; with CLK_DIV=1 it occurs in the first cycle after release.
  - frame_start follows in the next clk, because the counters are already at (0,0).
- Reset asserted mid-frame: counters and pipeline return to reset values on the next clk, with no partial sync pulse extension.
- video_data is ignored outside pix_en cycles and during blanking.

Test Plan:
- Reset then run, CLK_DIV=2 → pix_en on clk 1,3,5…; hcnt 0→1 at the first pix_en; frame_start is a single pulse after the first tick; hsync=1 and blank_b=0 during reset.
- Run one full line → hcnt wraps 799→0 while vcnt steps 0→1 on the same tick; hsync low for exactly 96 pixel ticks, its first low output 3 ticks (DATA_LAT+1) after hcnt=656.
- Run a full frame → vsync low for exactly 2 lines (vcnt 490,491 plus 3-tick delay); frame_start period = 800×525×2 = 840000 clk.
- Drive video_data=8'hE3 during the active area → R=8'hFF, G=8'h00, B=8'hFF; at hcnt=640 the aligned output goes to R=G=B=0 with blank_b=0.
- Memory model returning {hcnt[7:0]} with 2-tick latency → the R/G/B sequence matches the hcnt pattern with no off-by-one at line start (pixel 0 visible first).
- Assert reset for 1 clk mid-line (hcnt=300, vcnt=200) → next clk: hcnt=0, vcnt=0, hsync=1, blank_b=0, RGB=0; with CLK_DIV=1, pix_en=1 every clk after release.
